// File: rtl/sensor_conditioner.sv
// Input conditioning for the irrigation controller: synchronises the raw field
// pins, debounces them on a slow sample strobe, and emits one-cycle edge pulses.
module sensor_conditioner #(
  parameter int DIV = 50000,
  parameter int DEB = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [4:0] Raw,
  output logic [4:0] Lvl,
  output logic [4:0] Rise,
  output logic [4:0] Fall,
  output logic       Ready,
  output logic       Tick
);

  localparam int PW = $clog2(DIV);
  localparam int CW = $clog2(DEB);
  localparam logic [PW-1:0] PC_MAX  = PW'(DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB - 1);
  localparam logic [7:0]    RC_MAX  = 8'(DEB - 1);

  function automatic logic [7:0] satInc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [4:0]    rawSync_p0;
  logic [4:0]    rawSync_p1;
  logic          armed;
  logic [PW-1:0] pc;
  logic [CW-1:0] cnt [5];
  logic [7:0]    rc;
  logic [4:0]    flip;

  // Stage p0/p1: two-flop synchroniser on the asynchronous pins
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rawSync_p0 <= '0;
      rawSync_p1 <= '0;
    end else begin
      rawSync_p0 <= Raw;
      rawSync_p1 <= rawSync_p0;
    end
  end

  // The first edge after release only arms the prescaler, so the first strobe
  // period lines up with the synchroniser having filled.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      armed <= 1'b0;
      pc    <= '0;
    end else begin
      armed <= 1'b1;
      if (armed) pc <= (pc == PC_MAX) ? '0 : pc + 1'b1;
    end
  end

  assign Tick = (pc == PC_MAX);

  always_comb begin
    flip = '0;
    for (int i = 0; i < 5; i++)
      flip[i] = Tick && (rawSync_p1[i] != Lvl[i]) && (cnt[i] == CNT_MAX);
  end

  // Debounce: DEB consecutive differing samples accept the new level
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
      Lvl <= '0;
    end else if (Tick) begin
      for (int i = 0; i < 5; i++) begin
        if (rawSync_p1[i] == Lvl[i] || cnt[i] == CNT_MAX) cnt[i] <= '0;
        else                                               cnt[i] <= cnt[i] + 1'b1;
      end
      Lvl <= Lvl ^ flip;
    end
  end

  // Pulses use the pre-edge Ready, so a change on the qualifying tick is silent
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Rise <= '0;
      Fall <= '0;
    end else begin
      Rise <= Ready ? (flip & ~Lvl) : '0;
      Fall <= Ready ? (flip & Lvl)  : '0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rc    <= '0;
      Ready <= 1'b0;
    end else if (Tick) begin
      rc <= satInc8(rc);
      if (rc == RC_MAX) Ready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: directed scenarios with hand-derived timing plus
// a randomized run, all checked against an edge-count based reference model.
module tb_sensor_conditioner;

  localparam int DIV = 4;
  localparam int DEB = 3;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [4:0] Raw = 5'b0;
  logic [4:0] Lvl, Rise, Fall;
  logic       Ready, Tick;

  sensor_conditioner #(.DIV(DIV), .DEB(DEB)) dut (
    .Clk(Clk), .Rst(Rst), .Raw(Raw), .Lvl(Lvl), .Rise(Rise), .Fall(Fall),
    .Ready(Ready), .Tick(Tick)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: mE = clock edges since reset release; a sample strobe is
  // visible whenever mE is a nonzero multiple of DIV; the pins reach the
  // sampler through a two-deep delay; a level flips after DEB strobes in a row
  // disagree with it; Ready once DEB*DIV edges have elapsed at a strobe.
  int         mE = 0;
  logic [4:0] mD1 = 0, mD2 = 0, mLvl = 0, mRise = 0, mFall = 0;
  logic       mReady = 0;
  int         mRun [5] = '{0, 0, 0, 0, 0};

  function automatic logic strobeNow();
    return Rst && (mE >= DIV) && (mE % DIV == 0);
  endfunction

  initial forever begin
    @(posedge Clk or negedge Rst);
    if (!Rst) begin
      mE = 0; mD1 = 0; mD2 = 0; mLvl = 0; mRise = 0; mFall = 0; mReady = 0;
      for (int c = 0; c < 5; c++) mRun[c] = 0;
    end else begin
      mRise = 0;
      mFall = 0;
      if (strobeNow()) begin
        for (int c = 0; c < 5; c++) begin
          if (mD2[c] != mLvl[c]) mRun[c]++;
          else                   mRun[c] = 0;
          if (mRun[c] == DEB) begin
            mRun[c] = 0;
            if (mReady) begin
              if (mD2[c]) mRise[c] = 1'b1;
              else        mFall[c] = 1'b1;
            end
            mLvl[c] = mD2[c];
          end
        end
        if (mE >= DEB * DIV) mReady = 1'b1;
      end
      mD2 = mD1;
      mD1 = Raw;
      if (mE < 1000000) mE++;
    end
  end

  initial forever begin
    @(negedge Clk);
    check("outputs{Lvl,Rise,Fall,Ready,Tick}", {Lvl, Rise, Fall, Ready, Tick},
          {mLvl, mRise, mFall, mReady, strobeNow()});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic settleLow();
    @(negedge Clk);
    Raw = 5'b0;
    repeat (20) @(negedge Clk);
    check("settle_low_Lvl", Lvl, 5'b0);
  endtask

  task automatic waitPulse(input string name, output int n);
    n = 0;
    do begin
      @(posedge Clk); #1;
      n++;
    end while ((Rise | Fall) == 5'b0 && n < 40);
    if ((Rise | Fall) == 5'b0) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic waitTick();
    int k = 0;
    do begin
      @(negedge Clk);
      k++;
    end while (!Tick && k < 20);
    check("tick_seen", Tick, 1'b1);
  endtask

  initial begin
    int n;
    int k;
    logic [4:0] lvlSeen;
    logic [4:0] pulseSeen;

    // Reset with all pins high
    Raw = 5'b11111;
    #1 Rst = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_Lvl", Lvl, 5'b0);
    check("reset_Ready", Ready, 1'b0);
    Rst = 1'b1;
    repeat (12) @(posedge Clk);
    #1;
    check("edge12_Lvl", Lvl, 5'b0);
    check("edge12_Ready", Ready, 1'b0);
    @(posedge Clk); #1;
    check("edge13_Lvl", Lvl, 5'b11111);
    check("edge13_Ready", Ready, 1'b1);
    check("edge13_Rise", Rise, 5'b0);

    // Clean rise and fall on channel 0
    settleLow();
    @(negedge Clk);
    Raw = 5'b00001;
    waitPulse("rise0", n);
    check("rise0_latency_ok", (n <= 2 + DEB * DIV), 1'b1);
    check("rise0_Rise", Rise, 5'b00001);
    check("rise0_Lvl", Lvl, 5'b00001);
    check("rise0_Fall", Fall, 5'b0);
    @(posedge Clk); #1;
    check("rise0_width", Rise, 5'b0);
    @(negedge Clk);
    Raw = 5'b0;
    waitPulse("fall0", n);
    check("fall0_Fall", Fall, 5'b00001);
    check("fall0_Lvl", Lvl, 5'b0);
    @(posedge Clk); #1;
    check("fall0_width", Fall, 5'b0);

    // Bounce on channel 1: 3-cycle pulses never give DEB agreeing samples
    pulseSeen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      Raw[1] = ((i % 6) < 3);
      pulseSeen |= (Rise | Fall) & 5'b00010;
    end
    Raw[1] = 1'b0;
    check("bounce_pulses", pulseSeen, 5'b0);
    check("bounce_Lvl", Lvl, 5'b0);

    // Restart on agreement: 9 high, 4 low, then high, aligned to a strobe
    settleLow();
    waitTick();
    Raw[2] = 1'b1;
    lvlSeen = 0;
    for (int i = 0; i < 9; i++) begin @(negedge Clk); lvlSeen |= Lvl; end
    Raw[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin @(negedge Clk); lvlSeen |= Lvl; end
    Raw[2] = 1'b1;
    check("restart_no_early", lvlSeen, 5'b0);
    k = 13;
    while (!Lvl[2] && k < 60) begin
      @(negedge Clk);
      k++;
    end
    check("restart_cycle", k, 25);

    // Simultaneous qualification on three channels
    settleLow();
    @(negedge Clk);
    Raw = 5'b10101;
    waitPulse("simul", n);
    check("simul_Rise", Rise, 5'b10101);
    check("simul_Lvl", Lvl, 5'b10101);

    // Reset mid-qualification, asserted between clock edges
    @(negedge Clk);
    Raw = 5'b01000;
    waitTick();
    waitTick();
    #2 Rst = 1'b0;
    #1;
    check("midrst_outputs", {Lvl, Rise, Fall, Ready, Tick}, 17'b0);
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    repeat (12) @(posedge Clk);
    #1;
    check("midrst_edge12_Lvl", Lvl, 5'b0);
    @(posedge Clk); #1;
    check("midrst_edge13_Lvl", Lvl, 5'b01000);
    check("midrst_edge13_Ready", Ready, 1'b1);
    check("midrst_edge13_Rise", Rise, 5'b0);

    // Randomized pins with random hold times, one extra asynchronous reset
    for (int it = 0; it < 300; it++) begin
      @(negedge Clk);
      if ($urandom_range(0, 1) == 1) Raw = 5'($urandom_range(0, 31));
      else                           Raw = Raw ^ (5'b1 << $urandom_range(0, 4));
      if (it == 150) begin
        #3 Rst = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
      end
      repeat ($urandom_range(1, 30)) @(negedge Clk);
    end

    @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sensor_conditioner.md
# sensor_conditioner

Input-side conditioning block for the irrigation controller. It takes the raw, asynchronous, bouncing field inputs (humidity, level, valve and fertiliser switches, and the test input) and produces clean, debounced levels plus single-cycle edge pulses. The irrigation decision logic and both state machines read its outputs instead of the pins. It is the receiving counterpart of the display and actuator drive path.

## Interface
Parameters:
- DIV, default 50000: Clk cycles per sample strobe; 1 ms at 50 MHz. Legal values are DIV ≥ 2.
- DEB, default 8: number of consecutive differing samples needed to accept a new level. Legal values are 2 ≤ DEB ≤ 255.

Ports (name, direction, width, meaning):
- Clk, in, 1: system clock. This is the single clock; every register uses its rising edge.
- Rst, in, 1: reset. Asynchronous, active-low.
- Raw, in, 5: raw pins. Bit mapping is {T1, Adub, Vs, Bs, Us}, bit 0 = Us. The inputs are asynchronous to Clk.
- Lvl, out, 5: debounced levels, same bit mapping as Raw.
- Rise, out, 5: one-Clk pulse when the corresponding Lvl bit goes 0→1.
- Fall, out, 5: one-Clk pulse when the corresponding Lvl bit goes 1→0.
- Ready, out, 1: high once the initial qualification period has completed.
- Tick, out, 1: the internal sample strobe, exported for debug and for other blocks' timebase.

## Operation
- **Synchronizer:** each Raw bit passes through a 2-FF chain (S1, S2). Both stages reset to 0. All later logic uses S2 only.
- **Prescaler:**
  - The counter Pc runs 0..DIV-1 and wraps to 0.
  - Tick = 1 for exactly the one Clk cycle in which Pc = DIV-1.
  - Pc resets to 0.
- **Per-channel debounce.** The following are evaluated only in cycles with Tick = 1. Each channel has a stability counter Cnt of width ceil(log2(DEB)) that resets to 0.
  - If S2 = Lvl: Cnt ← 0.
  - If S2 ≠ Lvl and Cnt < DEB-1: Cnt ← Cnt+1.
  - If S2 ≠ Lvl and Cnt = DEB-1: Lvl ← S2 and Cnt ← 0. This means DEB consecutive differing samples are required.
  - A single agreeing sample in between restarts the count, so glitches shorter than one sample period are rejected.
  - In cycles with Tick = 0, Cnt and Lvl hold.
- **Edge pulses:**
  - Rise[i] and Fall[i] are registered. They are high for exactly one Clk cycle, concurrent with the first cycle in which the new Lvl[i] is visible.
  - Pulses are suppressed while Ready = 0. During that time Lvl still updates, but Rise and Fall stay 0.
- **Ready:**
  - A saturating counter Rc counts Ticks after reset.
  - Ready ← 1 on the DEB-th Tick. At that edge all channels whose pins were static have settled.
  - Ready then holds 1 until the next reset.
  - A Lvl change that takes effect on that same DEB-th Tick produces no pulse, because suppression is judged on the pre-edge value of Ready (0).
- **Channel independence:** channels are fully independent. Simultaneous qualification on several channels produces simultaneous pulses in the same cycle.
- **Output reset values:**
  - Lvl = 0, Rise = 0, Fall = 0, Ready = 0, Tick = 0.
  - All counters reset to 0.
- **Reset mid-operation:** reset asserted at any time clears everything immediately and asynchronously. No pulse is generated by the reset itself, and none is generated at reset release.

## Timing
- **Raw edge to Lvl change:**
  - Minimum: 2 synchronizer cycles plus (DEB-1)·DIV + 1 cycles.
  - Maximum: 2 + DEB·DIV cycles, depending on the phase relative to Tick.
- **Lvl, Rise, Fall and Ready** all change on the clock edge that samples Tick = 1. They are therefore visible in the cycle after Tick.
- **First Tick:** Pc reaches DIV-1 at the DIV-th rising edge after Rst deasserts. The first Tick is high in cycle DIV, counting cycles from 1.
- **Ready** rises after DEB·DIV + 1 edges following reset release.
- **Lower bound on rejected bounces:** any Raw pulse shorter than DIV−2 cycles is never seen by two consecutive samples. It cannot qualify unless DEB ticks land inside it.

## Test plan
All scenarios use DIV=4 and DEB=3 unless noted.

1. **Reset:** hold Rst=0 with Raw=5'b11111, then release. All outputs are 0 for the first 12 edges. Ready, Lvl=5'b11111 and Rise=0 all appear on the same edge, at 13 edges after release. Rise stays 0 throughout.
2. **Clean rise:** after Ready, set Raw[0]=1 and hold it.
   - Lvl[0]=1 within 2+12 cycles, with Rise[0] high for exactly 1 cycle at that point.
   - Fall=0 and all other bits unchanged.
   - Then release Raw[0]. Fall[0] pulses once and Lvl[0] returns to 0.
3. **Bounce rejection:** after Ready, toggle Raw[1] with period 6 cycles, giving 3-cycle pulses, for 100 cycles. Lvl[1] stays 0 and Rise[1]/Fall[1] never assert.
4. **Restart on agreement:**
   - Raw[2]=1 for 9 cycles, then 0 for 4, then 1 held. Lvl[2] rises only after 3 further consecutive Ticks see 1.
   - Check that Cnt restarts, so there is no early change around cycle 9.
5. **Simultaneous events:** after Ready, raise Raw[4:0] = 5'b10101 in the same cycle. Rise = 5'b10101 in a single cycle and Lvl = 5'b10101 on the same edge.
6. **Reset mid-qualification:**
   - Raw[3]=1, then assert Rst two Ticks later. Lvl, Rise, Fall and Ready go 0 asynchronously, with no clock edge required.
   - After release with Raw[3] still 1, Lvl[3] rises together with Ready at edge 13 after release. No Rise pulse is generated.
